// File: rtl/gpio_ctrl.sv
// GPIO controller: per-pin direction, atomic set/clear of outputs, synchronised
// inputs and per-pin edge interrupts behind an 8-word register file.
module gpio_ctrl #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic             re,
  input  logic [2:0]       addr,
  input  logic [31:0]      data_in,
  output logic [31:0]      data_out,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq
);

  localparam int unsigned DW = 32;

  localparam logic [2:0] ADDR_OUT     = 3'd0;
  localparam logic [2:0] ADDR_DIR     = 3'd1;
  localparam logic [2:0] ADDR_IN      = 3'd2;
  localparam logic [2:0] ADDR_IEN     = 3'd3;
  localparam logic [2:0] ADDR_ITYPE   = 3'd4;
  localparam logic [2:0] ADDR_STAT    = 3'd5;
  localparam logic [2:0] ADDR_OUT_SET = 3'd6;
  localparam logic [2:0] ADDR_OUT_CLR = 3'd7;

  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] ien_q, ien_d;
  logic [WIDTH-1:0] itype_q, itype_d;
  logic [WIDTH-1:0] stat_q, stat_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [DW-1:0]    data_out_q, data_out_d;
  logic             irq_q, irq_d;

  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] sync_out;
  logic [WIDTH-1:0] edge_ev;
  logic [WIDTH-1:0] stat_w1c;
  logic [DW-1:0]    rdata;

  // Synchroniser, edge detect, register writes and registered read data
  always_comb begin
    wdata     = data_in[WIDTH-1:0];
    sync_d[0] = gpio_in;
    for (int k = 1; k < int'(SYNC_STAGES); k++) begin
      sync_d[k] = sync_q[k-1];
    end
    sync_out = sync_q[SYNC_STAGES-1];
    prev_d   = sync_out;
    edge_ev  = (sync_out & ~prev_q & ~itype_q) | (~sync_out & prev_q & itype_q);

    out_d    = out_q;
    dir_d    = dir_q;
    ien_d    = ien_q;
    itype_d  = itype_q;
    stat_w1c = '0;
    if (we) begin
      case (addr)
        ADDR_OUT:     out_d    = wdata;
        ADDR_DIR:     dir_d    = wdata;
        ADDR_IEN:     ien_d    = wdata;
        ADDR_ITYPE:   itype_d  = wdata;
        ADDR_STAT:    stat_w1c = wdata;
        ADDR_OUT_SET: out_d    = out_q | wdata;
        ADDR_OUT_CLR: out_d    = out_q & ~wdata;
        default:      ;
      endcase
    end
    // A new edge beats a simultaneous clear
    stat_d = (stat_q & ~stat_w1c) | edge_ev;
    irq_d  = |(stat_d & ien_d);

    case (addr)
      ADDR_OUT:   rdata = DW'(out_q);
      ADDR_DIR:   rdata = DW'(dir_q);
      ADDR_IN:    rdata = DW'(sync_out);
      ADDR_IEN:   rdata = DW'(ien_q);
      ADDR_ITYPE: rdata = DW'(itype_q);
      ADDR_STAT:  rdata = DW'(stat_q);
      default:    rdata = '0;
    endcase
    data_out_d = re ? rdata : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_q      <= '0;
      dir_q      <= '0;
      ien_q      <= '0;
      itype_q    <= '0;
      stat_q     <= '0;
      prev_q     <= '0;
      sync_q     <= '0;
      data_out_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      out_q      <= out_d;
      dir_q      <= dir_d;
      ien_q      <= ien_d;
      itype_q    <= itype_d;
      stat_q     <= stat_d;
      prev_q     <= prev_d;
      sync_q     <= sync_d;
      data_out_q <= data_out_d;
      irq_q      <= irq_d;
    end
  end

  assign data_out = data_out_q;
  assign gpio_out = out_q;
  assign gpio_oe  = dir_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_gpio_ctrl.sv
// Self-checking bench for gpio_ctrl: directed scenarios plus random bus and pin
// traffic compared against a delay-line/register reference model.
module tb_gpio_ctrl;

  localparam int unsigned S = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic [2:0]  addr = 3'd0;
  logic [31:0] data_in = '0;
  logic [31:0] gpio_in = '0;

  logic [31:0] data_out, gpio_out, gpio_oe;
  logic        irq;
  logic [31:0] d8_dout;
  logic [7:0]  d8_out, d8_oe;
  logic        d8_irq;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [31:0] m_out, m_dir, m_ien, m_itype, m_stat, m_dout;
  logic        m_irq;
  logic [31:0] hist [S+1];

  gpio_ctrl #(.WIDTH(32), .SYNC_STAGES(S)) dut (
    .clk(clk), .reset(reset), .we(we), .re(re), .addr(addr), .data_in(data_in),
    .data_out(data_out), .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe),
    .irq(irq)
  );

  gpio_ctrl #(.WIDTH(8), .SYNC_STAGES(S)) dut8 (
    .clk(clk), .reset(reset), .we(we), .re(re), .addr(addr), .data_in(data_in),
    .data_out(d8_dout), .gpio_in(gpio_in[7:0]), .gpio_out(d8_out), .gpio_oe(d8_oe),
    .irq(d8_irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_out = '0; m_dir = '0; m_ien = '0; m_itype = '0; m_stat = '0;
    m_dout = '0; m_irq = 1'b0;
    for (int i = 0; i <= int'(S); i++) hist[i] = '0;
  endtask

  // IN is the pin value sampled S edges ago; prev is one edge older still
  task automatic model_step();
    logic [31:0] syn, prv, ev, w1c;
    syn = hist[S-1];
    prv = hist[S];
    ev  = (syn & ~prv & ~m_itype) | (~syn & prv & m_itype);
    if (re) begin
      case (addr)
        3'd0: m_dout = m_out;
        3'd1: m_dout = m_dir;
        3'd2: m_dout = syn;
        3'd3: m_dout = m_ien;
        3'd4: m_dout = m_itype;
        3'd5: m_dout = m_stat;
        default: m_dout = '0;
      endcase
    end else begin
      m_dout = '0;
    end
    w1c = '0;
    if (we) begin
      case (addr)
        3'd0: m_out = data_in;
        3'd1: m_dir = data_in;
        3'd3: m_ien = data_in;
        3'd4: m_itype = data_in;
        3'd5: w1c = data_in;
        3'd6: m_out = m_out | data_in;
        3'd7: m_out = m_out & ~data_in;
        default: ;
      endcase
    end
    m_stat = (m_stat & ~w1c) | ev;
    m_irq  = |(m_stat & m_ien);
    for (int i = int'(S); i >= 1; i--) hist[i] = hist[i-1];
    hist[0] = gpio_in;
  endtask

  task automatic cycle(input logic w, input logic r, input logic [2:0] a, input logic [31:0] d);
    we = w; re = r; addr = a; data_in = d;
    @(posedge clk);
    model_step();
    #1;
    check("dout", data_out, m_dout);
    check("gpio_out", gpio_out, m_out);
    check("gpio_oe", gpio_oe, m_dir);
    check("irq", 32'(irq), 32'(m_irq));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 3'd0, 32'h0);
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Reset state: every register reads back 0
    for (int a = 0; a < 8; a++) begin
      cycle(1'b0, 1'b1, 3'(a), 32'h0);
      check("rst_read", data_out, 32'h0);
    end
    check("rst_out", gpio_out, 32'h0);
    check("rst_oe", gpio_oe, 32'h0);
    check("rst_irq", 32'(irq), 32'h0);

    // Atomic set/clear
    cycle(1'b1, 1'b0, 3'd0, 32'hF0F0_F0F0);
    cycle(1'b1, 1'b0, 3'd6, 32'h0000_000F);
    cycle(1'b1, 1'b0, 3'd7, 32'hF000_0000);
    check("setclr_pins", gpio_out, 32'h00F0_F0FF);
    cycle(1'b0, 1'b1, 3'd0, 32'h0);
    check("setclr_read", data_out, 32'h00F0_F0FF);
    cycle(1'b0, 1'b1, 3'd6, 32'h0);
    check("rd_outset", data_out, 32'h0);
    cycle(1'b0, 1'b1, 3'd7, 32'h0);
    check("rd_outclr", data_out, 32'h0);

    // Narrow instance drops upper bits
    cycle(1'b1, 1'b0, 3'd1, 32'hFFFF_FFFF);
    check("w8_oe", 32'(d8_oe), 32'h0000_00FF);
    cycle(1'b0, 1'b1, 3'd1, 32'h0);
    check("w8_dir", d8_dout, 32'h0000_00FF);

    // Rising edge on pin 0 with interrupt enabled
    cycle(1'b1, 1'b0, 3'd3, 32'h1);
    gpio_in[0] = 1'b1;
    for (int k = 1; k <= int'(S); k++) begin
      cycle(1'b0, 1'b0, 3'd0, 32'h0);
      check("rise_irq_early", 32'(irq), 32'h0);
    end
    cycle(1'b0, 1'b1, 3'd2, 32'h0);
    check("rise_in", data_out & 32'h1, 32'h1);
    check("rise_irq", 32'(irq), 32'h1);
    cycle(1'b0, 1'b1, 3'd5, 32'h0);
    check("rise_stat", data_out, 32'h1);
    cycle(1'b1, 1'b0, 3'd5, 32'h1);
    check("w1c_irq", 32'(irq), 32'h0);

    // Falling edge on pin 3, interrupt masked then enabled
    cycle(1'b1, 1'b0, 3'd3, 32'h0);
    cycle(1'b1, 1'b0, 3'd4, 32'h8);
    gpio_in[3] = 1'b1;
    idle(S + 2);
    cycle(1'b1, 1'b0, 3'd5, 32'hFFFF_FFFF);
    gpio_in[3] = 1'b0;
    idle(S + 1);
    cycle(1'b0, 1'b1, 3'd5, 32'h0);
    check("fall_stat", data_out, 32'h8);
    check("fall_irq_masked", 32'(irq), 32'h0);
    cycle(1'b1, 1'b0, 3'd3, 32'h8);
    check("fall_irq_en", 32'(irq), 32'h1);

    // Edge lands on the same edge as its W1C: set wins
    gpio_in[3] = 1'b1;
    idle(S + 2);
    gpio_in[3] = 1'b0;
    idle(S);
    cycle(1'b1, 1'b0, 3'd5, 32'h8);
    cycle(1'b0, 1'b1, 3'd5, 32'h0);
    check("set_wins_stat", data_out & 32'h8, 32'h8);
    check("set_wins_irq", 32'(irq), 32'h1);

    // Asynchronous reset in the middle of a read
    cycle(1'b0, 1'b1, 3'd0, 32'h0);
    check("pre_rst_dout", data_out, 32'h00F0_F0FF);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("arst_dout", data_out, 32'h0);
    check("arst_out", gpio_out, 32'h0);
    check("arst_irq", 32'(irq), 32'h0);
    re = 1'b0;
    gpio_in = 32'h4;
    model_reset();
    #1;
    reset = 1'b1;
    idle(S);
    cycle(1'b0, 1'b1, 3'd5, 32'h0);
    check("rel_stat_early", data_out, 32'h0);
    cycle(1'b0, 1'b1, 3'd5, 32'h0);
    check("rel_stat", data_out, 32'h4);

    // Random bus and pin traffic
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) gpio_in = $urandom;
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            3'($urandom_range(0, 7)), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
